test_pulse_encoder: RTL and testbench

//  Producer side of the botonTest/pulseTest interface consumed by the Tamagotchi control unit (Dormir_Test).

---
 rtl/tamagotchi_pkg.sv | 15 +
 rtl/button_debouncer.sv | 60 ++++++
 rtl/test_pulse_encoder.sv | 120 ++++++++++++
 tb/tb_test_pulse_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the Tamagotchi button front-ends and control unit.
package tamagotchi_pkg;

  // Encoder FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  localparam int DEFAULT_PULSE_W         = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_WINDOW_CYCLES   = 20;

endpackage

// File: rtl/button_debouncer.sv
// Button front-end: 2-FF synchronizer, stable-level debouncer and a
// registered one-cycle pulse on each accepted rising edge (press).
// Shared by the test, sleep, awake, feed and play buttons.
module button_debouncer
  import tamagotchi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_press
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_pin;
  logic             w_sample;
  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Normalise polarity so that 1 always means "pressed" from here on.
  assign w_pin    = BTN_ACTIVE_LOW ? ~i_pin : i_pin;
  assign w_sample = r_sync[1];

  // Two-flop synchronizer; reset value is the released level.
  // NOTE: sequential state always uses <=, so every flop samples the pre-edge
  // values and the shift chain cannot collapse into a single stage.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], w_pin};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (w_sample == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_sample;
        r_cnt   <= '0;
        r_press <= w_sample;  // only the rising transition is a press
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/test_pulse_encoder.sv
// Test-button encoder: counts debounced presses until a quiet window
// expires, then emits a single-cycle botonTest strobe with pulseTest = count.
module test_pulse_encoder
  import tamagotchi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int WINDOW_CYCLES   = DEFAULT_WINDOW_CYCLES,
  parameter bit BTN_ACTIVE_LOW  = 1'b0,
  parameter int PULSE_W         = DEFAULT_PULSE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               botonRaw,
  output logic               botonTest,
  output logic [PULSE_W-1:0] pulseTest,
  output logic               busy
);

  localparam int                  TIMER_W    = $clog2(WINDOW_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [PULSE_W-1:0] COUNT_MAX  = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_press;
  logic                 w_timeout;
  logic                 w_enter_emit;
  logic                 w_busy;
  logic [PULSE_W-1:0]   r_count;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_strobe;
  logic [PULSE_W-1:0]   r_pulse;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debouncer (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (botonRaw),
    .o_press (w_press)
  );

  assign w_timeout = (r_timer == TIMER_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a press in the expiry cycle keeps the window open.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned
    // (which would infer a latch).
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (w_press)                 w_state_nxt = ST_COUNT;
        ST_COUNT: if (!w_press && w_timeout)   w_state_nxt = ST_EMIT;
        ST_EMIT:                               w_state_nxt = ST_IDLE;
        default:                               w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode: busy tracks COUNT; the strobe is loaded on entry to EMIT.
  always_comb begin
    w_busy       = (r_state == ST_COUNT);
    w_enter_emit = (r_state == ST_COUNT) && (w_state_nxt == ST_EMIT);
  end

  // Press counter (saturating) and quiet-window timer.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_count <= '0;
      r_timer <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (w_press) r_count <= PULSE_W'(1);
        end
        ST_COUNT: begin
          if (w_press) begin
            r_timer <= '0;
            if (r_count != COUNT_MAX) r_count <= r_count + PULSE_W'(1);
          end else if (w_timeout) begin
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        default: begin
          r_count <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  // Registered outputs; pulseTest holds until the next strobe or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_strobe <= 1'b0;
      r_pulse  <= '0;
    end else begin
      r_strobe <= w_enter_emit;
      if (w_enter_emit) r_pulse <= r_count;
    end
  end

  assign botonTest = r_strobe;
  assign pulseTest = r_pulse;
  assign busy      = w_busy;

endmodule

// File: tb/tb_test_pulse_encoder.sv
// Directed bench for test_pulse_encoder (DEBOUNCE_CYCLES=4, WINDOW_CYCLES=20).
module tb_test_pulse_encoder;

  localparam int DEB = 4;
  localparam int WIN = 20;
  localparam int PW  = 4;
  // Raw rising edge to strobe: 2 sync + DEB debounce + 1 FSM + WIN window.
  localparam int LAT = 2 + DEB + 1 + WIN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          botonRaw = 1'b0;
  logic          botonTest;
  logic [PW-1:0] pulseTest;
  logic          busy;

  test_pulse_encoder #(
    .DEBOUNCE_CYCLES (DEB),
    .WINDOW_CYCLES   (WIN),
    .BTN_ACTIVE_LOW  (1'b0),
    .PULSE_W         (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .botonRaw  (botonRaw),
    .botonTest (botonTest),
    .pulseTest (pulseTest),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor (sampled on the falling edge).
  int   n_strobe = 0;
  int   sum_strobe = 0;
  int   last_strobe_cyc = -1;
  int   n_double = 0;
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (botonTest === 1'b1) begin
      n_strobe++;
      sum_strobe += int'(pulseTest);
      last_strobe_cyc = cyc;
      if (prev_strobe === 1'b1) n_double++;
    end
    prev_strobe = botonTest;
  end

  int n_vec = 0;
  int n_bad = 0;
  int held_pulse = 0;

  typedef struct {
    int n_press;
    int hi;
    int lo;
    bit bouncy;
    bit exp_busy;
    int exp_n;
    int exp_pulse;
    bit lat_first;  // strobe timed from the first press (later presses lost)
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_seq(input string tag, input int n, input int hi, input int lo,
                           input bit bouncy, input bit exp_busy,
                           output int first_rise, output int last_rise);
    first_rise = -1;
    last_rise  = -1;
    for (int p = 0; p < n; p++) begin
      if (bouncy) begin
        botonRaw = 1'b1; next_cyc();
        botonRaw = 1'b0; next_cyc();
      end
      botonRaw = 1'b1;
      if (p == 0) first_rise = cyc;
      last_rise = cyc;
      for (int j = 0; j < hi; j++) begin
        @(negedge clk);
        if (p == 0 && j == 6) check($sformatf("%s busy before press", tag), busy, 0);
        if (p == 0 && j == 7) check($sformatf("%s busy after press", tag), busy, exp_busy);
        next_cyc();
      end
      botonRaw = 1'b0;
      repeat (lo) next_cyc();
    end
  endtask

  task automatic expect_after(input string tag, input int base_n, input int base_sum,
                              input int exp_n, input int exp_pulse, input int exp_cyc);
    check($sformatf("%s strobe count", tag), n_strobe - base_n, exp_n);
    check($sformatf("%s pulse sum", tag), sum_strobe - base_sum, exp_n * exp_pulse);
    if (exp_n > 0) begin
      check($sformatf("%s strobe cycle", tag), last_strobe_cyc, exp_cyc);
      held_pulse = exp_pulse;
    end
    check($sformatf("%s pulseTest held", tag), pulseTest, held_pulse);
    check($sformatf("%s busy idle", tag), busy, 0);
  endtask

  initial begin
    int bn, bs, fr, lr;

    //           n   hi  lo bnc busy n  pulse first
    vecs[0]  = '{5,  10, 10, 0, 1,  1,  5, 0};  // clean presses, each on the expiry cycle
    vecs[1]  = '{1,  10, 10, 1, 1,  1,  1, 0};  // bouncy press
    vecs[2]  = '{1,  3,  10, 0, 0,  0,  0, 0};  // 3-cycle glitch rejected
    vecs[3]  = '{1,  4,  10, 0, 0,  1,  1, 0};  // exactly DEB stable cycles accepted
    vecs[4]  = '{17, 10, 8,  0, 1,  1, 15, 0};  // saturation
    vecs[5]  = '{16, 9,  9,  0, 1,  1, 15, 0};  // 16th press saturates
    vecs[6]  = '{14, 10, 10, 0, 1,  1, 14, 0};  // just below saturation
    vecs[7]  = '{2,  10, 9,  0, 1,  1,  2, 0};  // press before expiry
    vecs[8]  = '{3,  10, 10, 0, 1,  1,  3, 0};  // presses exactly on expiry
    vecs[9]  = '{2,  10, 11, 0, 1,  1,  1, 1};  // second press lands in EMIT: ignored
    vecs[10] = '{2,  10, 12, 0, 1,  2,  1, 0};  // second press after EMIT: new burst

    // Reset held 25 cycles with an idle pin.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("reset botonTest", botonTest, 0);
      check("reset pulseTest", pulseTest, 0);
      check("reset busy", busy, 0);
    end
    next_cyc();
    rst = 1'b0;
    bn = n_strobe; bs = sum_strobe;
    repeat (150) next_cyc();
    expect_after("idle", bn, bs, 0, 0, 0);

    // Table-driven bursts.
    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      bn = n_strobe; bs = sum_strobe;
      press_seq(tag, vecs[i].n_press, vecs[i].hi, vecs[i].lo, vecs[i].bouncy,
                vecs[i].exp_busy, fr, lr);
      repeat (40) next_cyc();
      expect_after(tag, bn, bs, vecs[i].exp_n, vecs[i].exp_pulse,
                   (vecs[i].lat_first ? fr : lr) + LAT);
    end

    // rst mid-COUNT: collection discarded, pulseTest cleared.
    bn = n_strobe; bs = sum_strobe;
    press_seq("rst_mid", 3, 10, 10, 1'b0, 1'b1, fr, lr);
    @(negedge clk);
    check("rst_mid busy before rst", busy, 1);
    next_cyc();
    rst = 1'b1; next_cyc(); rst = 1'b0;
    held_pulse = 0;
    repeat (40) next_cyc();
    expect_after("rst_mid", bn, bs, 0, 0, 0);
    bn = n_strobe; bs = sum_strobe;
    press_seq("rst_after", 1, 10, 10, 1'b0, 1'b1, fr, lr);
    repeat (40) next_cyc();
    expect_after("rst_after", bn, bs, 1, 1, lr + LAT);

    // en low mid-COUNT: collection discarded, pulseTest keeps last value.
    bn = n_strobe; bs = sum_strobe;
    press_seq("en_mid", 3, 10, 10, 1'b0, 1'b1, fr, lr);
    en = 1'b0; next_cyc(); en = 1'b1;
    repeat (40) next_cyc();
    expect_after("en_mid", bn, bs, 0, 0, 0);
    bn = n_strobe; bs = sum_strobe;
    press_seq("en_after", 2, 10, 10, 1'b0, 1'b1, fr, lr);
    repeat (40) next_cyc();
    expect_after("en_after", bn, bs, 1, 2, lr + LAT);

    // Button pressed while disabled and still held at re-enable: no count.
    bn = n_strobe; bs = sum_strobe;
    en = 1'b0;
    botonRaw = 1'b1;
    repeat (20) next_cyc();
    en = 1'b1;
    repeat (20) next_cyc();
    @(negedge clk);
    check("held_reenable busy", busy, 0);
    next_cyc();
    botonRaw = 1'b0;
    repeat (40) next_cyc();
    expect_after("held_reenable", bn, bs, 0, 0, 0);

    check("strobe width one cycle", n_double, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
